// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory controller.
// FSM encoding, default geometry and address wrap helper.
package mem_ctrl_pkg;

  localparam int DEF_DWIDTH   = 16;
  localparam int DEF_AWIDTH   = 12;
  localparam int DEF_MEM_SIZE = 3840;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Next address with wrap at the last RAM word
  function automatic logic [31:0] wrap_inc(
    input logic [31:0] a,
    input int          size
  );
    return (a == 32'(size - 1)) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/bram_addr_gen.sv
// Loadable address counter that wraps at MEM_SIZE.
// Compare-and-reset increment, no divider.
module bram_addr_gen
  import mem_ctrl_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [AWIDTH-1:0] base,
  input  logic              step,
  output logic [AWIDTH-1:0] addr
);

  // Load a base address or advance with wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (step) begin
      addr <= AWIDTH'(wrap_inc(32'(addr), MEM_SIZE));
    end
  end

endmodule

// File: rtl/bram_copy_ctrl.sv
// Copy-with-add sequencer for a true dual-port BRAM.
// Port 0 reads, port 1 writes, one word per cycle.
module bram_copy_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] src_base,
  input  logic [AWIDTH-1:0] dst_base,
  input  logic [AWIDTH-1:0] num_words,
  input  logic [DWIDTH-1:0] add_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  input  logic [DWIDTH-1:0] q0,
  output logic [AWIDTH-1:0] addr1,
  output logic              ce1,
  output logic              we1,
  output logic [DWIDTH-1:0] d1
);

  state_t state, state_n;

  logic [AWIDTH-1:0] n_q, k_q, k_n;
  logic [DWIDTH-1:0] add_q;
  logic [AWIDTH-1:0] dst_addr;
  logic [AWIDTH-1:0] da;
  logic              va;
  logic              busy_n, done_n, err_n, ce0_n;
  logic              load, step, bad;

  assign we0 = 1'b0;
  assign we1 = ce1;
  assign bad = (num_words == '0) ||
               (32'(num_words) > 32'(MEM_SIZE));

  bram_addr_gen #(
    .AWIDTH   (AWIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_src (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .base    (src_base),
    .step    (step),
    .addr    (addr0)
  );

  bram_addr_gen #(
    .AWIDTH   (AWIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_dst (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .base    (dst_base),
    .step    (step),
    .addr    (dst_addr)
  );

  // Next state and next values of the registered outputs
  always_comb begin
    state_n = state;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ce0_n   = ce0;
    k_n     = k_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          k_n  = '0;
          if (bad) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = RUN;
            busy_n  = 1'b1;
            ce0_n   = 1'b1;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        k_n  = k_q + 1'b1;
        if (k_q == n_q - 1'b1) begin
          state_n = DRAIN;
          ce0_n   = 1'b0;
        end
      end
      DRAIN: begin
        if (!va) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, latched request and control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ce0   <= 1'b0;
      k_q   <= '0;
      n_q   <= '0;
      add_q <= '0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
      ce0   <= ce0_n;
      k_q   <= k_n;
      if (load) begin
        n_q   <= num_words;
        add_q <= add_val;
      end
    end
  end

  // Two-stage valid/address pipe alongside the read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      va    <= 1'b0;
      da    <= '0;
      ce1   <= 1'b0;
      addr1 <= '0;
      d1    <= '0;
    end else begin
      va  <= ce0;
      ce1 <= va;
      if (ce0) begin
        da <= dst_addr;
      end
      if (va) begin
        addr1 <= da;
        d1    <= q0 + add_q;
      end
    end
  end

endmodule
